pitch_sequencer: RTL
====================

# pitch_sequencer

Upstream game controller for the pitching LED display. Turns a player start press and switch settings into a timed `pitch` window with a latched `speed` code and `mode`, which drive the LED controller directly. Counts pitches per game, stops after a fixed number, and picks a pseudo-random speed when auto mode is selected. Runs entirely on the 1 Hz game tick.

## Interface
- `FLIGHT_TICKS`, default 16: clk_1hz cycles `pitch` is held high per pitch (≥1).
- `COOLDOWN_TICKS`, default 2: idle ticks after a pitch before a new start is accepted (≥1).
- `MAX_PITCHES`, default 9: pitches per game (1..15).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01.
- `clk_1hz`  in  1  game tick; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level button, sampled on clk_1hz; a 0→1 sample is a start request.
- `mode_sel`  in  2  requested mode; 2'b00 is treated as 2'b01.
- `auto_speed`  in  1  1 = speed from LFSR, 0 = from `speed_sw`.
- `speed_sw`  in  4  manual speed code; values >8 clamp to 8.
- `pitch`  out  1  high for the whole flight window.
- `speed`  out  4  latched speed code 0..8 (120 + 5·code km/h; ≥4 selects fast LED rate downstream).
- `mode`  out  2  latched mode, never 2'b00 after first pitch.
- `pitch_cnt`  out  4  completed pitches this game.
- `busy`  out  1  high in WINDUP, FLIGHT, COOLDOWN.
- `game_over`  out  1  high in DONE.

## Operation
- Start detect: `start_q` register; `start_rise = start & ~start_q`. Rises outside IDLE are discarded, not queued.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every tick in every state including DONE.
- Auto speed: `r = lfsr[3:0]`; code = r if r ≤ 8, else r − 8 (9..15 → 1..7).
- States:
  - IDLE: waits; `start_rise` → WINDUP.
  - WINDUP: one tick; latches `speed`, `mode`; sets `pitch`=1, loads tick counter with FLIGHT_TICKS−1; → FLIGHT.
  - FLIGHT: counter decrements each tick; when counter = 0 it clears `pitch`, increments `pitch_cnt`; → DONE if new count = MAX_PITCHES, else → COOLDOWN with counter = COOLDOWN_TICKS−1.
  - COOLDOWN: counter decrements; at 0 → IDLE.
  - DONE: holds all outputs, `game_over`=1; exits only on `rst`.
- `speed` and `mode` are stable for the whole time `pitch`=1 and hold their values afterwards until the next WINDUP.
- `mode_sel`, `auto_speed`, `speed_sw` changes are ignored except at the WINDUP edge.
- Reset values: state IDLE, `pitch`=0, `speed`=0, `mode`=2'b01, `pitch_cnt`=0, `busy`=0, `game_over`=0, `start_q`=0, LFSR = seed. Mid-flight `rst` drops `pitch` immediately (asynchronous).

## Timing
- All outputs registered; no combinational input→output path.
- `start` sampled high at edge N, low at N−1: WINDUP at N, `pitch`/`speed`/`mode` valid after edge N+1.
- `pitch` high for exactly FLIGHT_TICKS edges (N+1 through N+FLIGHT_TICKS); falls at edge N+FLIGHT_TICKS+1 together with the `pitch_cnt` increment.
- Next start accepted at the earliest `start_rise` in IDLE, i.e. after COOLDOWN_TICKS further edges; a held `start` does not retrigger (a release is needed).
- Minimum pitch period: 1 + FLIGHT_TICKS + COOLDOWN_TICKS + 1 ticks.
- `start` held high through reset release: `start_q` resets to 0, so the first sampled 1 counts as a rise.

## Test plan
- Reset: assert `rst` mid-FLIGHT → `pitch`=0 at once; after release all outputs equal the reset values, LFSR = 8'hA5.
- Manual pitch: `auto_speed`=0, `speed_sw`=4'd12, `mode_sel`=2'b10, pulse `start` → `speed`=8, `mode`=2'b10, `pitch` high exactly 16 ticks, `pitch_cnt`=1, `busy` low 2 ticks after `pitch` falls.
- Mode default and latch: `mode_sel`=2'b00 at start, change to 2'b11 mid-flight → `mode` stays 2'b01 for the whole flight.
- Auto speed: `auto_speed`=1 → `speed` matches the reference LFSR model at the WINDUP edge and is always ≤8 over 200 pitches (several resets).
- Ignored starts: pulse `start` during FLIGHT and COOLDOWN → no extra pitch; hold `start` high across IDLE → no retrigger until it is released and pressed again.
- Game end: 9 pitches → `game_over`=1, `pitch_cnt`=9, further starts ignored; `rst` → IDLE with `pitch_cnt`=0.

Source files
------------

// File: rtl/pitch_sequencer.sv
// rtl/pitch_sequencer.sv - pitch timing, speed/mode latch and game counting on the 1 Hz tick
//
// Ports:
//   clk_1hz    game tick, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   start      level button; a sampled 0->1 is a start request (only honoured in IDLE)
//   mode_sel   requested mode, 2'b00 reads as 2'b01
//   auto_speed 1 = speed from LFSR, 0 = from speed_sw
//   speed_sw   manual speed code, clamped to 8
//   pitch      high for the flight window
//   speed      latched speed code 0..8
//   mode       latched mode
//   pitch_cnt  completed pitches this game
//   busy       high from WINDUP through COOLDOWN
//   game_over  high once MAX_PITCHES pitches have completed
module pitch_sequencer #(
    parameter int          FLIGHT_TICKS   = 16,
    parameter int          COOLDOWN_TICKS = 2,
    parameter int          MAX_PITCHES    = 9,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode_sel,
    input  logic       auto_speed,
    input  logic [3:0] speed_sw,
    output logic       pitch,
    output logic [3:0] speed,
    output logic [1:0] mode,
    output logic [3:0] pitch_cnt,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        WINDUP,
        FLIGHT,
        COOLDOWN,
        DONE
    } state_t;

    localparam int MAX_TICKS = (FLIGHT_TICKS > COOLDOWN_TICKS) ? FLIGHT_TICKS : COOLDOWN_TICKS;
    localparam int CW        = $clog2(MAX_TICKS) + 1;

    localparam logic [CW-1:0] FLIGHT_LOAD = CW'(FLIGHT_TICKS - 1);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(COOLDOWN_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [3:0]    MAX_CNT     = 4'(MAX_PITCHES);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0]    SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    state_t          state;
    logic            start_q;
    logic [7:0]      lfsr;
    logic [CW-1:0]   tick_cnt;

    logic            start_rise;
    logic            lfsr_fb;
    logic [3:0]      auto_code;
    logic [3:0]      manual_code;
    logic [1:0]      mode_req;
    logic [3:0]      cnt_next;

    always_comb begin
        start_rise  = start & ~start_q;
        // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
        lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        // Fold 9..15 down to 1..7 so the code always lands in 0..8.
        auto_code   = (lfsr[3:0] > 4'd8) ? (lfsr[3:0] - 4'd8) : lfsr[3:0];
        manual_code = (speed_sw > 4'd8) ? 4'd8 : speed_sw;
        mode_req    = (mode_sel == 2'b00) ? 2'b01 : mode_sel;
        cnt_next    = pitch_cnt + 4'd1;
    end

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            lfsr      <= SEED;
            tick_cnt  <= '0;
            pitch     <= 1'b0;
            speed     <= 4'd0;
            mode      <= 2'b01;
            pitch_cnt <= 4'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            start_q <= start;
            // The LFSR free-runs in every state so auto speeds depend on press timing.
            lfsr    <= {lfsr[6:0], lfsr_fb};

            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= WINDUP;
                        busy  <= 1'b1;
                    end
                end

                WINDUP: begin
                    speed    <= auto_speed ? auto_code : manual_code;
                    mode     <= mode_req;
                    pitch    <= 1'b1;
                    tick_cnt <= FLIGHT_LOAD;
                    state    <= FLIGHT;
                end

                FLIGHT: begin
                    if (tick_cnt == '0) begin
                        pitch     <= 1'b0;
                        pitch_cnt <= cnt_next;
                        if (cnt_next == MAX_CNT) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            state    <= COOLDOWN;
                            tick_cnt <= COOL_LOAD;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - CNT_ONE;
                    end
                end

                COOLDOWN: begin
                    if (tick_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tick_cnt <= tick_cnt - CNT_ONE;
                    end
                end

                DONE: begin
                    // Terminal until reset; outputs hold.
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
